// File: rtl/redor_seq.sv
// redor_seq: sequences an "any nonzero" test over a streamed row of beats.
//   redor_unit : combinational reduction-OR of one data beat.
//   redor_seq  : command-started job controller. It accepts len_i beats and
//                accumulates an any-nonzero flag, a count of nonzero beats and
//                the index of the first nonzero beat. The result is held until
//                the consumer takes it.
// Ports (redor_seq):
//   clk, rst           clock, synchronous active-high reset
//   start_i, len_i     job command; sampled only while idle
//   busy_o             job in progress or result pending
//   in_data_i/in_valid_i/in_ready_o   beat stream handshake
//   res_valid_o/res_ready_i           result handshake
//   res_any_o, res_cnt_o, res_first_o result fields (first = all-ones if none)

// Reduction-OR of one beat: high when any bit of the beat is set.
module redor_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] data,
    output logic             any_c
);
    assign any_c = |data;
endmodule

module redor_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_any_o,
    output logic [LEN_W-1:0] res_cnt_o,
    output logic [LEN_W-1:0] res_first_o
);
    // Sentinel for "no nonzero beat seen"; never a legal index since idx <= len-1 <= 2^LEN_W-2.
    localparam logic [LEN_W-1:0] FIRST_NONE = '1;
    localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;

    logic beat_nz_c;
    logic beat_fire_c;
    logic last_beat_c;

    redor_unit #(.WIDTH(WIDTH)) u_redor (
        .data  (in_data_i),
        .any_c (beat_nz_c)
    );

    assign beat_fire_c = in_valid_i && in_ready_o;
    assign last_beat_c = (idx_q == len_q - ONE);

    // Controller: state, job counters and registered outputs move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            res_any_o   <= 1'b0;
            res_cnt_o   <= '0;
            res_first_o <= FIRST_NONE;
            res_valid_o <= 1'b0;
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q       <= len_i;
                        idx_q       <= '0;
                        res_any_o   <= 1'b0;
                        res_cnt_o   <= '0;
                        res_first_o <= FIRST_NONE;
                        busy_o      <= 1'b1;
                        if (len_i != '0) begin
                            state_q    <= RUN;
                            in_ready_o <= 1'b1;
                        end else begin
                            // Empty job: result is immediately available.
                            state_q     <= DONE;
                            res_valid_o <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (beat_fire_c) begin
                        if (beat_nz_c) begin
                            res_any_o <= 1'b1;
                            res_cnt_o <= res_cnt_o + ONE;
                            if (res_first_o == FIRST_NONE) begin
                                res_first_o <= idx_q;
                            end
                        end
                        idx_q <= idx_q + ONE;
                        if (last_beat_c) begin
                            state_q     <= DONE;
                            in_ready_o  <= 1'b0;
                            res_valid_o <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Result fields stay as-is until the next start clears them.
                    if (res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    res_valid_o <= 1'b0;
                    in_ready_o  <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_redor_seq.sv
// Directed bench for redor_seq: expected results are computed from the
// beats the bench sends and queued at job start, then compared when the
// result handshake appears.
module tb_redor_seq;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned LEN_W = 8;

    typedef struct packed {
        logic             any;
        logic [LEN_W-1:0] cnt;
        logic [LEN_W-1:0] first;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic [WIDTH-1:0] in_data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             res_valid_o;
    logic             res_ready_i;
    logic             res_any_o;
    logic [LEN_W-1:0] res_cnt_o;
    logic [LEN_W-1:0] res_first_o;

    int n_tests = 0;
    int n_fail  = 0;

    res_t             exp_q[$];
    logic [WIDTH-1:0] job_beats[$];

    redor_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_any_o   (res_any_o),
        .res_cnt_o   (res_cnt_o),
        .res_first_o (res_first_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result for the beats in job_beats.
    function automatic res_t model();
        res_t r;
        r.any   = 1'b0;
        r.cnt   = '0;
        r.first = '1;
        for (int i = 0; i < job_beats.size(); i++) begin
            if (job_beats[i] != '0) begin
                if (!r.any) r.first = LEN_W'(i);
                r.any = 1'b1;
                r.cnt = r.cnt + LEN_W'(1);
            end
        end
        return r;
    endfunction

    task automatic start_job(input logic [LEN_W-1:0] len);
        start_i = 1'b1;
        len_i   = len;
        step();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    // Drive one beat after 'gap' idle cycles; the DUT must be ready when it is offered.
    task automatic beat(input string tag, input logic [WIDTH-1:0] d, input int gap);
        in_valid_i = 1'b0;
        repeat (gap) step();
        chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        in_data_i  = d;
        step();
        in_valid_i = 1'b0;
        in_data_i  = '0;
    endtask

    // Result must be valid now; compare it against the queued expectation.
    task automatic check_result(input string tag);
        res_t e;
        chk({tag, "_valid"}, 32'(res_valid_o), 32'd1);
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_any"},   32'(res_any_o),   32'(e.any));
            chk({tag, "_cnt"},   32'(res_cnt_o),   32'(e.cnt));
            chk({tag, "_first"}, 32'(res_first_o), 32'(e.first));
        end
    endtask

    task automatic consume(input string tag);
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk({tag, "_idle_busy"},  32'(busy_o),      32'd0);
        chk({tag, "_idle_valid"}, 32'(res_valid_o), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        len_i       = '0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        res_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_ready", 32'(in_ready_o),  32'd0);
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_any",   32'(res_any_o),   32'd0);
        chk("rst_cnt",   32'(res_cnt_o),   32'd0);
        chk("rst_first", 32'(res_first_o), 32'hFF);

        // Beats offered in IDLE are ignored
        in_valid_i = 1'b1;
        in_data_i  = 64'h1;
        step();
        in_valid_i = 1'b0;
        chk("idle_ready", 32'(in_ready_o), 32'd0);
        chk("idle_busy",  32'(busy_o),     32'd0);

        // Reset mid-RUN: partial job discarded, no result
        start_job(8'd4);
        chk("mid_busy", 32'(busy_o), 32'd1);
        beat("mid_b0", 64'h3, 0);
        beat("mid_b1", 64'h0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy",  32'(busy_o),      32'd0);
        chk("midrst_ready", 32'(in_ready_o),  32'd0);
        chk("midrst_valid", 32'(res_valid_o), 32'd0);
        chk("midrst_first", 32'(res_first_o), 32'hFF);
        chk("midrst_cnt",   32'(res_cnt_o),   32'd0);
        chk("midrst_any",   32'(res_any_o),   32'd0);
        step();
        chk("midrst_novalid", 32'(res_valid_o), 32'd0);

        // Mixed vector, back-to-back; result exactly one cycle after 5th handshake
        job_beats = '{64'h0, 64'h0, 64'h10, 64'h0, 64'h8000_0000_0000_0000};
        exp_q.push_back(model());
        start_job(8'd5);
        chk("mix_ready", 32'(in_ready_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("mix_notyet", 32'(res_valid_o), 32'd0);
            beat("mix_b", job_beats[i], 0);
        end
        check_result("mix");
        chk("mix_done_ready", 32'(in_ready_o), 32'd0);
        consume("mix");

        // All-zero with bubbles of 0, 2, 1 cycles; start_i in RUN is ignored
        job_beats = '{64'h0, 64'h0, 64'h0};
        exp_q.push_back(model());
        start_job(8'd3);
        start_i = 1'b1;
        len_i   = 8'd1;
        beat("bub_b0", job_beats[0], 0);
        beat("bub_b1", job_beats[1], 2);
        chk("bub_mid_valid", 32'(res_valid_o), 32'd0);
        beat("bub_b2", job_beats[2], 1);
        start_i = 1'b0;
        len_i   = '0;
        check_result("bub");
        consume("bub");
        step();
        chk("bub_after_valid", 32'(res_valid_o), 32'd0);
        chk("bub_after_busy",  32'(busy_o),      32'd0);

        // Zero-length job goes straight to DONE
        job_beats.delete();
        exp_q.push_back(model());
        start_job(8'd0);
        chk("zero_ready", 32'(in_ready_o), 32'd0);
        check_result("zero");
        consume("zero");

        // Result backpressure: outputs hold, start/in_valid ignored in DONE
        job_beats = '{64'h0, 64'h40};
        exp_q.push_back(model());
        start_job(8'd2);
        beat("bp_b0", job_beats[0], 0);
        beat("bp_b1", job_beats[1], 0);
        for (int i = 0; i < 5; i++) begin
            start_i    = i[0];
            len_i      = 8'd7;
            in_valid_i = ~i[0];
            in_data_i  = 64'hFFFF;
            step();
            chk("bp_hold_valid", 32'(res_valid_o), 32'd1);
            chk("bp_hold_ready", 32'(in_ready_o),  32'd0);
            chk("bp_hold_cnt",   32'(res_cnt_o),   32'd1);
            chk("bp_hold_first", 32'(res_first_o), 32'd1);
        end
        start_i    = 1'b0;
        len_i      = '0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        check_result("bp");
        consume("bp");
        job_beats = '{64'h5};
        exp_q.push_back(model());
        start_job(8'd1);
        beat("bp2_b0", job_beats[0], 0);
        check_result("bp2");
        consume("bp2");

        // Max length: 255 beats of 1
        job_beats.delete();
        for (int i = 0; i < 255; i++) job_beats.push_back(64'h1);
        exp_q.push_back(model());
        start_job(8'd255);
        for (int i = 0; i < 254; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = job_beats[i];
            step();
        end
        in_valid_i = 1'b0;
        chk("max_254_valid", 32'(res_valid_o), 32'd0);
        chk("max_254_ready", 32'(in_ready_o),  32'd1);
        beat("max_last", job_beats[254], 0);
        check_result("max");
        consume("max");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
